// File: rtl/irq_pkg.sv
// Shared constants and types for the interrupt controller slice.
// Holds source/group counts, bus widths, register addresses, the base
// vector and the per-group priority type.
package irq_pkg;

  localparam int unsigned NUM_IRQ    = 16;
  localparam int unsigned NUM_GROUPS = 8;
  localparam int unsigned IDX_W      = 4;
  localparam int unsigned ADDR_W     = 24;
  localparam int unsigned DATA_W     = 8;
  localparam int unsigned VEC_W      = 6;

  localparam logic [VEC_W-1:0] VECTOR_BASE = 6'h03;

  localparam logic [ADDR_W-1:0] ADDR_PRIO_LO    = 24'h002020;
  localparam logic [ADDR_W-1:0] ADDR_PRIO_HI    = 24'h002021;
  localparam logic [ADDR_W-1:0] ADDR_ENABLE_LO  = 24'h002022;
  localparam logic [ADDR_W-1:0] ADDR_ENABLE_HI  = 24'h002023;
  localparam logic [ADDR_W-1:0] ADDR_FLAGS_LO   = 24'h002024;
  localparam logic [ADDR_W-1:0] ADDR_FLAGS_HI   = 24'h002025;
  localparam logic [ADDR_W-1:0] ADDR_PENDING_LO = 24'h002026;
  localparam logic [ADDR_W-1:0] ADDR_PENDING_HI = 24'h002027;

  typedef logic [1:0] prio_t;

endpackage

// File: rtl/irq_controller_if.sv
// Peripheral bus bundle seen by the interrupt controller.
//   bus_write      : one-cycle write strobe
//   bus_read       : read strobe, informational only
//   bus_address_in : byte address
//   bus_data_in    : write data
//   bus_data_out   : read data, combinational from the address
interface irq_controller_if;
  import irq_pkg::*;

  logic              bus_write;
  logic              bus_read;
  logic [ADDR_W-1:0] bus_address_in;
  logic [DATA_W-1:0] bus_data_in;
  logic [DATA_W-1:0] bus_data_out;

  modport master (
    output bus_write, bus_read, bus_address_in, bus_data_in,
    input  bus_data_out
  );

  modport slave (
    input  bus_write, bus_read, bus_address_in, bus_data_in,
    output bus_data_out
  );

endinterface

// File: rtl/irq_prio_select.sv
// Combinational winner selection among pending sources.
//   pending      : per-source pending bits (flags & enable)
//   prio         : 2-bit priority per group of two sources, 0 = masked
//   winner_idx   : lowest-index source holding the highest non-zero priority
//   winner_level : that priority, 0 when nothing is a candidate
module irq_prio_select
  import irq_pkg::*;
(
  input  logic [NUM_IRQ-1:0]    pending,
  input  prio_t [NUM_GROUPS-1:0] prio,
  output logic [IDX_W-1:0]      winner_idx,
  output prio_t                 winner_level
);

  // Ascending scan with strict '>' keeps the lowest index on ties.
  always_comb begin
    winner_idx   = '0;
    winner_level = '0;
    for (int unsigned i = 0; i < NUM_IRQ; i++) begin
      if (pending[i] && (prio[i >> 1] > winner_level)) begin
        winner_idx   = IDX_W'(i);
        winner_level = prio[i >> 1];
      end
    end
  end

endmodule

// File: rtl/irq_controller.sv
// Interrupt controller: edge-detects 16 source lines into W1C flags, masks
// them with per-source enables and per-group priorities, and presents the
// highest-priority pending request to the CPU through registered outputs.
// Owns registers 0x2020-0x2027 on the peripheral bus.
//   clk, reset (async, active-low)
//   bus          : peripheral bus slave (irq_controller_if)
//   irq_sources  : peripheral interrupt lines, active-high
//   irq_ack      : CPU acknowledge of the presented request
//   irq_req      : request pending (level > 0)
//   irq_vector   : vector of the presented request, held when idle
//   irq_level    : priority of the presented request
// Build option: define IRQ_AUTO_CLEAR_EN to clear the acknowledged flag on irq_ack.
module irq_controller
  import irq_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  irq_controller_if.slave    bus,
  input  logic [NUM_IRQ-1:0] irq_sources,
  input  logic               irq_ack,
  output logic               irq_req,
  output logic [VEC_W-1:0]   irq_vector,
  output prio_t              irq_level
);

  logic [NUM_IRQ-1:0] src_q;
  logic [NUM_IRQ-1:0] flags_q;
  logic [NUM_IRQ-1:0] enable_q;
  logic [NUM_IRQ-1:0] prio_q;

  logic [NUM_IRQ-1:0] edge_c;
  logic [NUM_IRQ-1:0] set_c;
  logic [NUM_IRQ-1:0] clr_c;
  logic [NUM_IRQ-1:0] pending_c;
  logic [IDX_W-1:0]   win_idx;
  prio_t              win_level;

`ifdef IRQ_AUTO_CLEAR_EN
  logic [IDX_W-1:0]   ack_idx_q;
  logic               unused_c;
  assign unused_c = bus.bus_read;
`else
  logic               unused_c;
  assign unused_c = bus.bus_read ^ irq_ack;
`endif

  assign edge_c    = irq_sources & ~src_q;
  assign set_c     = edge_c & enable_q;
  assign pending_c = flags_q & enable_q;

  // Flag clear sources: bus write-1-clear and, optionally, the acknowledge.
  always_comb begin
    clr_c = '0;
    if (bus.bus_write && (bus.bus_address_in == ADDR_FLAGS_LO)) begin
      clr_c[7:0] = bus.bus_data_in;
    end
    if (bus.bus_write && (bus.bus_address_in == ADDR_FLAGS_HI)) begin
      clr_c[15:8] = bus.bus_data_in;
    end
`ifdef IRQ_AUTO_CLEAR_EN
    if (irq_ack && irq_req) begin
      clr_c[ack_idx_q] = 1'b1;
    end
`endif
  end

  // Register read mux; unmapped addresses read as zero.
  always_comb begin
    bus.bus_data_out = '0;
    case (bus.bus_address_in)
      ADDR_PRIO_LO:    bus.bus_data_out = prio_q[7:0];
      ADDR_PRIO_HI:    bus.bus_data_out = prio_q[15:8];
      ADDR_ENABLE_LO:  bus.bus_data_out = enable_q[7:0];
      ADDR_ENABLE_HI:  bus.bus_data_out = enable_q[15:8];
      ADDR_FLAGS_LO:   bus.bus_data_out = flags_q[7:0];
      ADDR_FLAGS_HI:   bus.bus_data_out = flags_q[15:8];
      ADDR_PENDING_LO: bus.bus_data_out = pending_c[7:0];
      ADDR_PENDING_HI: bus.bus_data_out = pending_c[15:8];
      default:         bus.bus_data_out = '0;
    endcase
  end

  irq_prio_select u_prio_select (
    .pending      (pending_c),
    .prio         (prio_q),
    .winner_idx   (win_idx),
    .winner_level (win_level)
  );

  // Edge detect, flags (set wins over clear) and configuration registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      src_q    <= '0;
      flags_q  <= '0;
      enable_q <= '0;
      prio_q   <= '0;
    end else begin
      src_q   <= irq_sources;
      flags_q <= (flags_q & ~clr_c) | set_c;
      if (bus.bus_write) begin
        case (bus.bus_address_in)
          ADDR_PRIO_LO:   prio_q[7:0]    <= bus.bus_data_in;
          ADDR_PRIO_HI:   prio_q[15:8]   <= bus.bus_data_in;
          ADDR_ENABLE_LO: enable_q[7:0]  <= bus.bus_data_in;
          ADDR_ENABLE_HI: enable_q[15:8] <= bus.bus_data_in;
          default:        ;
        endcase
      end
    end
  end

  // Registered CPU-facing request; the vector holds while idle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      irq_req    <= 1'b0;
      irq_vector <= '0;
      irq_level  <= '0;
    end else begin
      irq_req   <= (win_level != 2'd0);
      irq_level <= win_level;
      if (win_level != 2'd0) begin
        irq_vector <= VECTOR_BASE + VEC_W'(win_idx);
      end
    end
  end

`ifdef IRQ_AUTO_CLEAR_EN
  // Source index of the presented vector, so an ack clears the right flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ack_idx_q <= '0;
    end else if (win_level != 2'd0) begin
      ack_idx_q <= win_idx;
    end
  end
`endif

endmodule

// File: tb/tb_irq_controller.sv
// Self-checking bench for irq_controller: directed scenarios plus a
// randomized run against a behavioural model of the register map,
// flag rules and priority selection.
module tb_irq_controller;

  logic        clk;
  logic        reset;
  logic [15:0] irq_sources;
  logic        irq_ack;
  logic        irq_req;
  logic [5:0]  irq_vector;
  logic [1:0]  irq_level;

  int checks;
  int errors;

  irq_controller_if bus_if ();

  irq_controller dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus_if.slave),
    .irq_sources (irq_sources),
    .irq_ack     (irq_ack),
    .irq_req     (irq_req),
    .irq_vector  (irq_vector),
    .irq_level   (irq_level)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // ---------------- behavioural model ----------------
  bit [15:0] m_src;
  bit [15:0] m_flags;
  bit [15:0] m_en;
  int        m_prio [8];
  bit        m_req;
  bit [5:0]  m_vec;
  int        m_lvl;

  task automatic model_reset();
    m_src = '0; m_flags = '0; m_en = '0;
    for (int g = 0; g < 8; g++) m_prio[g] = 0;
    m_req = 0; m_vec = '0; m_lvl = 0;
  endtask

  // Highest level first, then lowest source index within that level.
  task automatic find_winner(output int idx, output int lvl);
    bit [15:0] pend;
    pend = m_flags & m_en;
    idx = 0; lvl = 0;
    for (int l = 3; l >= 1 && lvl == 0; l--) begin
      for (int i = 0; i < 16; i++) begin
        if (pend[i] && m_prio[i / 2] == l) begin
          idx = i; lvl = l;
          break;
        end
      end
    end
  endtask

  function automatic bit [7:0] m_read(input bit [23:0] a);
    bit [7:0]  r;
    bit [15:0] pend;
    pend = m_flags & m_en;
    r = 8'h00;
    case (a)
      24'h002020: for (int g = 0; g < 4; g++) r = r | 8'((m_prio[g] & 3) << (2 * g));
      24'h002021: for (int g = 0; g < 4; g++) r = r | 8'((m_prio[g + 4] & 3) << (2 * g));
      24'h002022: r = m_en[7:0];
      24'h002023: r = m_en[15:8];
      24'h002024: r = m_flags[7:0];
      24'h002025: r = m_flags[15:8];
      24'h002026: r = pend[7:0];
      24'h002027: r = pend[15:8];
      default:    r = 8'h00;
    endcase
    return r;
  endfunction

  // Apply one clock edge to both the DUT and the model, then settle at +1.
  task automatic tick();
    int        widx, wlvl;
    bit [15:0] edg, clr, nflags, nen;
    int        nprio [8];
    bit [7:0]  d;
    find_winner(widx, wlvl);
    edg = irq_sources & ~m_src;
    clr = '0;
    nen = m_en;
    nprio = m_prio;
    d = bus_if.bus_data_in;
    if (bus_if.bus_write) begin
      case (bus_if.bus_address_in)
        24'h002020: for (int g = 0; g < 4; g++) nprio[g]     = (d >> (2 * g)) & 3;
        24'h002021: for (int g = 0; g < 4; g++) nprio[g + 4] = (d >> (2 * g)) & 3;
        24'h002022: nen[7:0]  = d;
        24'h002023: nen[15:8] = d;
        24'h002024: clr[7:0]  = d;
        24'h002025: clr[15:8] = d;
        default: ;
      endcase
    end
`ifdef IRQ_AUTO_CLEAR_EN
    if (irq_ack && m_req) clr[int'(m_vec) - 3] = 1'b1;
`endif
    nflags = (m_flags & ~clr) | (edg & m_en);
    @(posedge clk);
    #1;
    m_flags = nflags;
    m_en    = nen;
    m_prio  = nprio;
    m_src   = irq_sources;
    m_req   = (wlvl > 0);
    m_lvl   = wlvl;
    if (wlvl > 0) m_vec = 6'(3 + widx);
  endtask

  task automatic bus_wr(input logic [23:0] a, input logic [7:0] d);
    bus_if.bus_write      = 1'b1;
    bus_if.bus_address_in = a;
    bus_if.bus_data_in    = d;
    tick();
    bus_if.bus_write = 1'b0;
  endtask

  task automatic bus_rd(input logic [23:0] a, output logic [7:0] d);
    bus_if.bus_address_in = a;
    bus_if.bus_read       = 1'b1;
    #1;
    d = bus_if.bus_data_out;
    bus_if.bus_read = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [7:0] rd;
    reset = 1'b0;
    irq_sources = 16'h0001;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (irq_req !== 1'b0) begin
      errors++; $display("FAIL reset_req_during: got %b expected 0", irq_req);
    end
    reset = 1'b1;
    model_reset();
    #1;
    checks++;
    if ({irq_req, irq_vector, irq_level} !== 9'h000) begin
      errors++; $display("FAIL reset_outputs: got req=%b vec=%h lvl=%h expected all 0", irq_req, irq_vector, irq_level);
    end
    for (int a = 0; a < 8; a++) begin
      bus_rd(24'h002020 + 24'(a), rd);
      checks++;
      if (rd !== 8'h00) begin
        errors++; $display("FAIL reset_read_%0d: got %h expected 00", a, rd);
      end
    end
    tick();
    irq_sources = 16'h0000;
    tick();
    bus_rd(24'h002024, rd);
    checks++;
    if (rd !== 8'h00 || irq_req !== 1'b0) begin
      errors++; $display("FAIL reset_no_edge: got flags=%h req=%b expected 00/0", rd, irq_req);
    end
  endtask

  task automatic test_single_timer();
    logic [7:0] rd;
    bus_wr(24'h002022, 8'h03);
    bus_wr(24'h002020, 8'h02);
    irq_sources = 16'h0001;
    tick();
    bus_rd(24'h002024, rd);
    checks++;
    if (rd !== 8'h01 || irq_req !== 1'b0) begin
      errors++; $display("FAIL single_flag_edge_n: got flags=%h req=%b expected 01/0", rd, irq_req);
    end
    tick();
    checks++;
    if (irq_req !== 1'b1 || irq_vector !== 6'h03 || irq_level !== 2'd2) begin
      errors++; $display("FAIL single_present: got req=%b vec=%h lvl=%0d expected 1/03/2", irq_req, irq_vector, irq_level);
    end
    bus_wr(24'h002024, 8'h01);
    tick();
    checks++;
    if (irq_req !== 1'b0 || irq_level !== 2'd0 || irq_vector !== 6'h03) begin
      errors++; $display("FAIL single_cleared: got req=%b vec=%h lvl=%0d expected 0/03/0", irq_req, irq_vector, irq_level);
    end
  endtask

  task automatic test_priority();
    bus_wr(24'h002022, 8'hFF);
    bus_wr(24'h002023, 8'hFF);
    bus_wr(24'h002020, 8'h31);
    bus_wr(24'h002021, 8'h00);
    irq_sources = 16'h0000;
    bus_wr(24'h002024, 8'hFF);
    bus_wr(24'h002025, 8'hFF);
    irq_sources = 16'h0012;
    tick();
    tick();
    checks++;
    if (irq_req !== 1'b1 || irq_vector !== 6'h07 || irq_level !== 2'd3) begin
      errors++; $display("FAIL prio_high_group: got req=%b vec=%h lvl=%0d expected 1/07/3", irq_req, irq_vector, irq_level);
    end
    irq_sources = 16'h0000;
    bus_wr(24'h002024, 8'hFF);
    bus_wr(24'h002020, 8'h02);
    irq_sources = 16'h0003;
    tick();
    tick();
    checks++;
    if (irq_req !== 1'b1 || irq_vector !== 6'h03 || irq_level !== 2'd2) begin
      errors++; $display("FAIL prio_tie_low_index: got req=%b vec=%h lvl=%0d expected 1/03/2", irq_req, irq_vector, irq_level);
    end
  endtask

  task automatic test_masking();
    logic [7:0] rd;
    irq_sources = 16'h0000;
    bus_wr(24'h002022, 8'hDF);
    bus_wr(24'h002024, 8'hFF);
    irq_sources = 16'h0020;
    tick();
    tick();
    bus_rd(24'h002024, rd);
    checks++;
    if (rd !== 8'h00 || irq_req !== 1'b0 || irq_vector !== 6'h03) begin
      errors++; $display("FAIL mask_disabled_edge: got flags=%h req=%b vec=%h expected 00/0/03", rd, irq_req, irq_vector);
    end
    irq_sources = 16'h0000;
    bus_wr(24'h002022, 8'hFF);
    bus_wr(24'h002020, 8'h00);
    irq_sources = 16'h0020;
    tick();
    tick();
    bus_rd(24'h002026, rd);
    checks++;
    if (rd !== 8'h20 || irq_req !== 1'b0 || irq_level !== 2'd0) begin
      errors++; $display("FAIL mask_prio_zero: got pending=%h req=%b lvl=%0d expected 20/0/0", rd, irq_req, irq_level);
    end
    bus_wr(24'h002022, 8'h00);
    bus_rd(24'h002024, rd);
    checks++;
    if (rd !== 8'h20) begin
      errors++; $display("FAIL mask_flag_kept: got flags=%h expected 20", rd);
    end
  endtask

  task automatic test_collision();
    logic [7:0] rd;
    irq_sources = 16'h0000;
    bus_wr(24'h002022, 8'h03);
    bus_wr(24'h002024, 8'hFF);
    irq_sources = 16'h0002;
    tick();
    irq_sources = 16'h0000;
    tick();
    irq_sources = 16'h0002;
    bus_wr(24'h002024, 8'h02);
    bus_rd(24'h002024, rd);
    checks++;
    if (rd !== 8'h02) begin
      errors++; $display("FAIL collision_set_wins: got flags=%h expected 02", rd);
    end
    bus_wr(24'h002024, 8'h02);
    bus_rd(24'h002024, rd);
    checks++;
    if (rd !== 8'h00) begin
      errors++; $display("FAIL collision_plain_clear: got flags=%h expected 00", rd);
    end
  endtask

  task automatic test_ack();
    logic [7:0] rd;
    logic [7:0] exp_flag;
    logic       exp_req;
`ifdef IRQ_AUTO_CLEAR_EN
    exp_flag = 8'h00; exp_req = 1'b0;
`else
    exp_flag = 8'h01; exp_req = 1'b1;
`endif
    irq_sources = 16'h0000;
    bus_wr(24'h002022, 8'h01);
    bus_wr(24'h002020, 8'h02);
    bus_wr(24'h002024, 8'hFF);
    bus_wr(24'h002025, 8'hFF);
    irq_sources = 16'h0001;
    tick();
    tick();
    checks++;
    if (irq_req !== 1'b1 || irq_vector !== 6'h03) begin
      errors++; $display("FAIL ack_presented: got req=%b vec=%h expected 1/03", irq_req, irq_vector);
    end
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    bus_rd(24'h002024, rd);
    checks++;
    if (rd !== exp_flag) begin
      errors++; $display("FAIL ack_flag: got flags=%h expected %h", rd, exp_flag);
    end
    tick();
    checks++;
    if (irq_req !== exp_req) begin
      errors++; $display("FAIL ack_req_next: got req=%b expected %b", irq_req, exp_req);
    end
  endtask

  task automatic test_random();
    logic [7:0]  rd;
    logic [23:0] ra;
    for (int n = 0; n < 400; n++) begin
      irq_sources = irq_sources ^ (16'($urandom) & 16'($urandom));
      irq_ack = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 2) == 0) begin
        bus_if.bus_write      = 1'b1;
        bus_if.bus_address_in = 24'h00201F + 24'($urandom_range(0, 9));
        bus_if.bus_data_in    = 8'($urandom);
        if (bus_if.bus_address_in == 24'h002024 || bus_if.bus_address_in == 24'h002025)
          bus_if.bus_data_in = bus_if.bus_data_in & 8'($urandom);
      end
      tick();
      bus_if.bus_write = 1'b0;
      irq_ack = 1'b0;
      checks++;
      if (irq_req !== m_req || irq_vector !== m_vec || irq_level !== 2'(m_lvl)) begin
        errors++;
        $display("FAIL rand_outputs_%0d: got req=%b vec=%h lvl=%0d expected %b/%h/%0d",
                 n, irq_req, irq_vector, irq_level, m_req, m_vec, m_lvl);
      end
      ra = 24'h00201F + 24'($urandom_range(0, 9));
      bus_rd(ra, rd);
      checks++;
      if (rd !== m_read(ra)) begin
        errors++; $display("FAIL rand_read_%0d: addr=%h got %h expected %h", n, ra, rd, m_read(ra));
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    irq_sources = '0;
    irq_ack = 1'b0;
    bus_if.bus_write = 1'b0;
    bus_if.bus_read = 1'b0;
    bus_if.bus_address_in = '0;
    bus_if.bus_data_in = '0;
    model_reset();
    test_reset();
    test_single_timer();
    test_priority();
    test_masking();
    test_collision();
    test_ack();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
